// File: rtl/regfile_pkg.sv
// Shared definitions for the CPU register file and its consumers
// (comparator, ALU).
//   REGFILE_DATA_W / REGFILE_ADDR_W : default data and address widths
//   REG_ZERO                        : hard-wired zero register address
//   reg_addr_t / reg_data_t         : address and data word types
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W = 32;
  localparam int unsigned REGFILE_ADDR_W = 5;

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
//   clk, rst         : clock, asynchronous active-high reset
//   iss_valid/iss_wa : issuing instruction marks its destination busy
//   we/wa            : writeback clears the busy bit of its destination
//   busy             : busy vector (bit 0 is always 0)
//   pending          : registered count of set busy bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_wa,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        pending
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy_next;
  logic [ADDR_W:0]  count_next;

  // Clear is applied before set so that a newer issue to the same
  // register wins over the writeback of the older result.
  always_comb begin
    busy_next = busy;
    if (we && (wa != '0)) begin
      busy_next[wa] = 1'b0;
    end
    if (iss_valid && (iss_wa != '0)) begin
      busy_next[iss_wa] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Counting the next-state vector keeps pending exact (no underflow on
  // clears of idle registers, no double count on set-and-clear).
  always_comb begin
    count_next = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      count_next = count_next + (ADDR_W+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy    <= busy_next;
      pending <= count_next;
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read/one-write CPU register file with write-to-read bypass and a
// pending-write scoreboard for decode stalls.
//   clk, rst          : clock, asynchronous active-high reset
//   ra1/ra2, rd1/rd2  : combinational read ports
//   we/wa/wd          : writeback port
//   iss_valid/iss_wa  : issue of an instruction that will write iss_wa
//   busy1/busy2/stall : operand not yet available / either busy
//   pending           : number of registers with a write in flight
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_wa,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic [ADDR_W:0]   pending
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              wr_en;
  logic              byp1;
  logic              byp2;

  assign wr_en = we && (wa != '0);
  assign byp1  = wr_en && (wa == ra1);
  assign byp2  = wr_en && (wa == ra2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Register 0 reads zero even if its storage were ever disturbed.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) begin
      rd1 = byp1 ? wd : regs[ra1];
    end
    if (ra2 != '0) begin
      rd2 = byp2 ? wd : regs[ra2];
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .we        (we),
    .wa        (wa),
    .busy      (busy),
    .pending   (pending)
  );

  // A value arriving on writeback this cycle is already available.
  assign busy1 = busy[ra1] & ~byp1;
  assign busy2 = busy[ra2] & ~byp2;
  assign stall = busy1 | busy2;

endmodule
